// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// Dump sequencer states, register-count helper, read-port limit.
package regfile_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_DONE
  } dump_state_t;

  localparam int RD_PORTS_MAX = 4;

  function automatic int nregs(input int w);
    return 1 << w;
  endfunction

endpackage

// File: rtl/regfile_dump_seq.sv
// Debug dump sequencer: walks every register address and
// streams one word per accepted valid/ready beat.
module regfile_dump_seq
  import regfile_pkg::*;
#(
  parameter int B = 32,
  parameter int W = 5
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_start,
  input  logic         i_ready,
  input  logic [B-1:0] i_rdata,
  output logic [W-1:0] o_addr,
  output logic         o_valid,
  output logic         o_busy,
  output logic         o_done,
  output logic [B-1:0] o_data
);

  localparam int NREGS = nregs(W);
  localparam logic [W-1:0] LAST = W'(NREGS - 1);

  dump_state_t state;

  assign o_data = i_rdata;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= ST_IDLE;
      o_addr  <= '0;
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            state   <= ST_SEND;
            o_addr  <= '0;
            o_valid <= 1'b1;
            o_busy  <= 1'b1;
          end
        end
        ST_SEND: begin
          if (i_ready) begin
            if (o_addr == LAST) begin
              // Address parks on the last word; no wrap.
              state   <= ST_DONE;
              o_valid <= 1'b0;
              o_busy  <= 1'b0;
              o_done  <= 1'b1;
            end else begin
              o_addr <= o_addr + 1'b1;
            end
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          o_done <= 1'b0;
        end
        default: begin
          state   <= ST_IDLE;
          o_valid <= 1'b0;
          o_busy  <= 1'b0;
          o_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port GPR file with debug write port and dump sequencer.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to reads.
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int B        = 32,
  parameter int W        = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_reg_write_MC,
  input  logic [W-1:0]     i_write_register,
  input  logic [B-1:0]     i_write_data,
  input  logic [NRD*W-1:0] i_read_regs,
  output logic [NRD*B-1:0] o_read_data,
  input  logic             i_dbg_write,
  input  logic [W-1:0]     i_dbg_waddr,
  input  logic [B-1:0]     i_dbg_wdata,
  input  logic             i_dbg_dump_start,
  input  logic             i_dbg_ready,
  output logic             o_dbg_valid,
  output logic [W-1:0]     o_dbg_addr,
  output logic [B-1:0]     o_dbg_data,
  output logic             o_dbg_busy,
  output logic             o_dbg_done
);

  localparam int NREGS = nregs(W);
  localparam int NPORT =
    (NRD > RD_PORTS_MAX) ? RD_PORTS_MAX : NRD;

  logic [NREGS-1:0][B-1:0] regs;
  logic [B-1:0]            dump_rdata;

  function automatic logic hard_zero(
    input logic [W-1:0] a
  );
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Pipeline write is applied last so it wins an address clash.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      regs <= '0;
    end else begin
      if (i_dbg_write && !hard_zero(i_dbg_waddr))
        regs[i_dbg_waddr] <= i_dbg_wdata;
      if (i_reg_write_MC && !hard_zero(i_write_register))
        regs[i_write_register] <= i_write_data;
    end
  end

  genvar k;
  for (k = 0; k < NPORT; k++) begin : g_rd
    logic [W-1:0] ra;
    logic [B-1:0] rv;

    assign ra = i_read_regs[k*W +: W];

    always_comb begin
      rv = regs[ra];
`ifdef REGFILE_BYPASS_EN
      if (!i_reset) begin
        if (i_reg_write_MC && ra == i_write_register)
          rv = i_write_data;
        else if (i_dbg_write && ra == i_dbg_waddr)
          rv = i_dbg_wdata;
      end
`endif
      if (hard_zero(ra))
        rv = '0;
    end

    assign o_read_data[k*B +: B] = rv;
  end

  assign dump_rdata =
    hard_zero(o_dbg_addr) ? '0 : regs[o_dbg_addr];

  regfile_dump_seq #(
    .B (B),
    .W (W)
  ) u_dump (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_start (i_dbg_dump_start),
    .i_ready (i_dbg_ready),
    .i_rdata (dump_rdata),
    .o_addr  (o_dbg_addr),
    .o_valid (o_dbg_valid),
    .o_busy  (o_dbg_busy),
    .o_done  (o_dbg_done),
    .o_data  (o_dbg_data)
  );

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp (B=32, W=5, NRD=2).
// Inputs change 1 time unit after posedge; outputs sampled 1 unit later.
module tb_register_file_mp;

  localparam int B = 32;
  localparam int W = 5;
  localparam int NRD = 2;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             we;
  logic [W-1:0]     wa;
  logic [B-1:0]     wd;
  logic [NRD*W-1:0] rr;
  logic [NRD*B-1:0] rd;
  logic             dwe;
  logic [W-1:0]     dwa;
  logic [B-1:0]     dwd;
  logic             dstart;
  logic             dready;
  logic             dvalid;
  logic [W-1:0]     daddr;
  logic [B-1:0]     ddata;
  logic             dbusy;
  logic             ddone;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  register_file_mp #(
    .B (B), .W (W), .NRD (NRD), .ZERO_REG (1)
  ) dut (
    .i_clk            (clk),
    .i_reset          (rst),
    .i_reg_write_MC   (we),
    .i_write_register (wa),
    .i_write_data     (wd),
    .i_read_regs      (rr),
    .o_read_data      (rd),
    .i_dbg_write      (dwe),
    .i_dbg_waddr      (dwa),
    .i_dbg_wdata      (dwd),
    .i_dbg_dump_start (dstart),
    .i_dbg_ready      (dready),
    .o_dbg_valid      (dvalid),
    .o_dbg_addr       (daddr),
    .o_dbg_data       (ddata),
    .o_dbg_busy       (dbusy),
    .o_dbg_done       (ddone)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic rd_addr(input logic [W-1:0] a0,
                         input logic [W-1:0] a1);
    rr = {a1, a0};
  endtask

  initial begin
    int idx;
    int cyc;
    logic [B-1:0] v;

    rst = 1'b1; we = 1'b0; wa = '0; wd = '0;
    rr = '0; dwe = 1'b0; dwa = '0; dwd = '0;
    dstart = 1'b0; dready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    rd_addr(5'd5, 5'd31);
    settle();
    check("rst_valid", {31'd0, dvalid}, 32'd0);
    check("rst_busy", {31'd0, dbusy}, 32'd0);
    check("rst_done", {31'd0, ddone}, 32'd0);
    check("rst_addr", {27'd0, daddr}, 32'd0);
    check("rst_rd0", rd[31:0], 32'd0);
    check("rst_rd1", rd[63:32], 32'd0);
    check("rst_ddata", ddata, 32'd0);

    // Pipeline write r5, same-cycle and next-cycle read
    tick();
    we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
    rd_addr(5'd5, 5'd5);
    settle();
    check("wr5_same_p0", rd[31:0], BYP ? 32'hDEADBEEF : 32'd0);
    check("wr5_same_p1", rd[63:32], BYP ? 32'hDEADBEEF : 32'd0);
    tick();
    we = 1'b0;
    settle();
    check("wr5_next_p0", rd[31:0], 32'hDEADBEEF);
    check("wr5_next_p1", rd[63:32], 32'hDEADBEEF);

    // Same-address clash, then disjoint dual write
    tick();
    we = 1'b1; wa = 5'd3; wd = 32'h11;
    dwe = 1'b1; dwa = 5'd3; dwd = 32'h22;
    rd_addr(5'd3, 5'd0);
    settle();
    check("clash_byp", rd[31:0], BYP ? 32'h11 : 32'd0);
    tick();
    wa = 5'd4; wd = 32'h33;
    dwa = 5'd7; dwd = 32'h44;
    rd_addr(5'd7, 5'd4);
    settle();
    check("dbg_byp_r7", rd[31:0], BYP ? 32'h44 : 32'd0);
    tick();
    we = 1'b0; dwe = 1'b0;
    rd_addr(5'd4, 5'd3);
    settle();
    check("dual_r4", rd[31:0], 32'h33);
    check("clash_r3", rd[63:32], 32'h11);
    rd_addr(5'd7, 5'd5);
    settle();
    check("dual_r7", rd[31:0], 32'h44);
    check("keep_r5", rd[63:32], 32'hDEADBEEF);

    // r0 stays hardwired zero, never forwarded
    tick();
    we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF;
    dwe = 1'b1; dwa = 5'd0; dwd = 32'hFFFFFFFF;
    rd_addr(5'd0, 5'd0);
    settle();
    check("r0_same", rd[31:0], 32'd0);
    tick();
    we = 1'b0; dwe = 1'b0;
    settle();
    check("r0_p0", rd[31:0], 32'd0);
    check("r0_p1", rd[63:32], 32'd0);

    // Same-cycle read of r9 during its write
    tick();
    we = 1'b1; wa = 5'd9; wd = 32'hCAFE;
    rd_addr(5'd9, 5'd9);
    settle();
    check("r9_same_p0", rd[31:0], BYP ? 32'hCAFE : 32'd0);
    check("r9_same_p1", rd[63:32], BYP ? 32'hCAFE : 32'd0);
    tick();
    we = 1'b0;
    settle();
    check("r9_next", rd[31:0], 32'hCAFE);

    // Load r_k = k through the debug port (r0 gets all-ones)
    for (int k = 0; k < 32; k++) begin
      tick();
      dwe = 1'b1; dwa = W'(k);
      dwd = (k == 0) ? 32'hFFFFFFFF : 32'(k);
    end
    tick();
    dwe = 1'b0;

    // Dump with ready toggling every other cycle
    dstart = 1'b1;
    tick();
    dstart = 1'b0;
    settle();
    check("dump_valid0", {31'd0, dvalid}, 32'd1);
    check("dump_busy0", {31'd0, dbusy}, 32'd1);
    idx = 0;
    cyc = 0;
    while (idx < 32 && cyc < 200) begin
      dready = cyc[0];
      settle();
      if (dvalid && dready) begin
        check($sformatf("dump_addr%0d", idx),
              {27'd0, daddr}, 32'(idx));
        check($sformatf("dump_data%0d", idx),
              ddata, 32'(idx));
        idx++;
      end
      check("dump_nodone", {31'd0, ddone}, 32'd0);
      tick();
      cyc++;
    end
    check("dump_count", 32'(idx), 32'd32);
    dready = 1'b0;
    settle();
    check("done_pulse", {31'd0, ddone}, 32'd1);
    check("done_valid", {31'd0, dvalid}, 32'd0);
    check("done_busy", {31'd0, dbusy}, 32'd0);
    tick();
    check("done_clear", {31'd0, ddone}, 32'd0);
    check("idle_busy", {31'd0, dbusy}, 32'd0);

    // Reset mid-dump at address 10
    dstart = 1'b1;
    dready = 1'b1;
    tick();
    dstart = 1'b0;
    cyc = 0;
    while (daddr != 5'd10 && cyc < 64) begin
      tick();
      cyc++;
    end
    check("mid_addr10", {27'd0, daddr}, 32'd10);
    check("mid_busy", {31'd0, dbusy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    check("mrst_valid", {31'd0, dvalid}, 32'd0);
    check("mrst_busy", {31'd0, dbusy}, 32'd0);
    check("mrst_addr", {27'd0, daddr}, 32'd0);
    for (int n = 0; n < 4; n++) begin
      check("mrst_nodone", {31'd0, ddone}, 32'd0);
      tick();
    end
    for (int a = 1; a < 32; a += 6) begin
      rd_addr(W'(a), W'(a + 1));
      settle();
      v = rd[31:0] | rd[63:32];
      check($sformatf("mrst_clear%0d", a), v, 32'd0);
    end
    check("mrst_ddata", ddata, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
